// File: rtl/mult_pkg.sv
// Shared constants and helpers for arbiters fronting the shared 8x8 multiplier.
package mult_pkg;

    localparam int MULT_IN_W  = 8;
    localparam int MULT_OUT_W = 16;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Round-robin search: first set bit of valid at or after ptr, wrapping modulo n (n <= 8).
    // Returns ptr when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_search(input logic [7:0] valid,
                                             input int         n,
                                             input logic [2:0] ptr);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       hit;
        pick = ptr;
        idx  = ptr;
        hit  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < n && !hit) begin
                idx = 3'((int'(ptr) + k) % n);
                if (valid[idx]) begin
                    pick = idx;
                    hit  = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/multiplier_fast.sv
// Single-cycle combinational unsigned multiplier, full-width product.
module multiplier_fast
    import mult_pkg::*;
(
    input  logic [MULT_IN_W-1:0]  a,
    input  logic [MULT_IN_W-1:0]  b,
    output logic [MULT_OUT_W-1:0] p
);

    assign p = MULT_OUT_W'(a) * MULT_OUT_W'(b);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters,
// with a one-entry registered response tagged by requester index.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*MULT_IN_W-1:0]   req_a,
    input  logic [NUM_REQ*MULT_IN_W-1:0]   req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [MULT_OUT_W-1:0]          rsp_product,
    output logic [ID_W-1:0]                rsp_id
);

    rsp_state_e             state_p1;
    rsp_state_e             state_nxt;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        gnt_p0;
    logic                   any_vld_p0;
    logic                   can_accept;
    logic                   accept_p0;
    logic [7:0]             vld_ext;
    logic [MULT_IN_W-1:0]   a_p0;
    logic [MULT_IN_W-1:0]   b_p0;
    logic [MULT_OUT_W-1:0]  prod_p0;
    logic [MULT_OUT_W-1:0]  prod_p1;
    logic [ID_W-1:0]        id_p1;

    // Stage p0: grant selection and operand mux into the shared multiplier
    assign vld_ext    = 8'(req_valid);
    assign any_vld_p0 = |req_valid;
    assign gnt_p0     = ID_W'(rr_search(vld_ext, NUM_REQ, 3'(ptr)));
    assign a_p0       = req_a[gnt_p0*MULT_IN_W +: MULT_IN_W];
    assign b_p0       = req_b[gnt_p0*MULT_IN_W +: MULT_IN_W];

    multiplier_fast u_mult (
        .a (a_p0),
        .b (b_p0),
        .p (prod_p0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= RSP_EMPTY;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_p1;
        req_ready  = '0;
        accept_p0  = 1'b0;
        can_accept = (state_p1 == RSP_EMPTY) || rsp_ready;
        if (!rst && can_accept && any_vld_p0) begin
            req_ready[gnt_p0] = 1'b1;
            accept_p0         = 1'b1;
        end
        case (state_p1)
            RSP_EMPTY: if (accept_p0) state_nxt = RSP_FULL;
            RSP_FULL:  if (rsp_ready) state_nxt = accept_p0 ? RSP_FULL : RSP_EMPTY;
            default:   state_nxt = RSP_EMPTY;
        endcase
    end

    // Stage p1: response register; product/id change only on an accept
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p1 <= '0;
            id_p1   <= '0;
            ptr     <= '0;
        end else if (accept_p0) begin
            prod_p1 <= prod_p0;
            id_p1   <= gnt_p0;
            ptr     <= gnt_p0 + ID_W'(1);
        end
    end

    assign rsp_valid   = (state_p1 == RSP_FULL);
    assign rsp_product = prod_p1;
    assign rsp_id      = id_p1;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: directed scenarios plus random traffic.
module tb_mult_share_arbiter;

    localparam int N = 4;

    typedef struct {
        int id;
        int prod;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [15:0]    rsp_product;
    logic [1:0]     rsp_id;

    int   errors = 0;
    int   checks = 0;
    exp_t expq[$];
    int   opa[N];
    int   opb[N];
    int   m_ptr  = 0;
    bit   m_full = 0;
    bit   last_acc;
    int   last_g;

    mult_share_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; entered and left 2 time units after a rising edge.
    task automatic cycle(input logic [N-1:0] v, input logic rr, input logic r);
        int exp_ready;
        int g;
        bit acc;
        req_valid = v;
        rsp_ready = rr;
        rst       = r;
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8] = 8'(opa[i]);
            req_b[i*8 +: 8] = 8'(opb[i]);
        end
        #1;
        acc = 0;
        g   = 0;
        if (!r && (!m_full || rr)) begin
            for (int k = 0; k < N; k++) begin
                if (!acc && v[(m_ptr + k) % N]) begin
                    g   = (m_ptr + k) % N;
                    acc = 1;
                end
            end
        end
        exp_ready = acc ? (1 << g) : 0;
        check("req_ready", int'(req_ready), exp_ready);
        check("rsp_valid", int'(rsp_valid), int'(m_full));
        if (acc) expq.push_back('{id: g, prod: opa[g] * opb[g]});
        @(posedge clk);
        #2;
        if (r) begin
            m_full = 0;
            m_ptr  = 0;
            expq.delete();
        end else if (acc) begin
            m_full = 1;
            m_ptr  = (g + 1) % N;
        end else if (rr) begin
            m_full = 0;
        end
        last_acc = acc;
        last_g   = g;
    endtask

    // Monitor: every presented response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d product=%0d expected none", rsp_id, rsp_product);
            end else begin
                check("rsp_id", int'(rsp_id), expq[0].id);
                check("rsp_product", int'(rsp_product), expq[0].prod);
                if (rsp_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] v;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = 0;
            opb[i] = 0;
        end
        repeat (2) @(posedge clk);
        #2;
        cycle(4'b1111, 1'b1, 1'b1);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_product", int'(rsp_product), 0);
        check("reset_rsp_id", int'(rsp_id), 0);

        // single request
        opa[0] = 5;
        opb[0] = 10;
        cycle(4'b0001, 1'b1, 1'b0);
        #3;
        check("single_product", int'(rsp_product), 50);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);

        // all four valid from ptr=0
        cycle(4'b0000, 1'b0, 1'b1);
        opa = '{1, 127, 200, 13};
        opb = '{255, 2, 3, 19};
        for (int k = 0; k < 5; k++) cycle(4'b1111, 1'b1, 1'b0);
        check("rr_fifth_grant", last_g, 0);

        // backpressure with 255*255 held
        opa = '{255, 255, 255, 255};
        opb = '{255, 255, 255, 255};
        cycle(4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(4'b1111, 1'b0, 1'b0);
        check("bp_product_held", int'(rsp_product), 65025);
        cycle(4'b1111, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);

        // pointer wrap
        cycle(4'b0000, 1'b0, 1'b1);
        opa = '{3, 4, 5, 6};
        opb = '{7, 8, 9, 10};
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b1010, 1'b1, 1'b0);
        check("wrap_grant3", last_g, 3);
        cycle(4'b0010, 1'b1, 1'b0);
        check("wrap_grant1", last_g, 1);
        cycle(4'b0000, 1'b1, 1'b0);

        // reset while FULL with requests pending
        cycle(4'b1111, 1'b1, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1);
        check("midrst_rsp_valid", int'(rsp_valid), 0);
        check("midrst_rsp_product", int'(rsp_product), 0);
        cycle(4'b0110, 1'b1, 1'b0);
        check("midrst_first_grant", last_g, 1);
        cycle(4'b0000, 1'b1, 1'b0);

        // random traffic, operands held while pending
        v = '0;
        last_acc = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && !(last_acc && last_g == i))) begin
                    v[i]   = 1'($urandom_range(0, 1));
                    opa[i] = int'($urandom % 256);
                    opb[i] = int'($urandom % 256);
                end
            end
            cycle(v, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int k = 0; k < 4; k++) cycle(4'b0000, 1'b1, 1'b0);
        check("scoreboard_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one combinational 8x8 unsigned multiplier (multiplier_fast) among NUM_REQ requesters.
- Round-robin arbitration per cycle, valid/ready handshake on each request port, and a one-entry registered response stage tagged with the requester index.
- Sits between the compute clients and the shared multiplier so the datapath is instantiated once.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester tag; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*8  packed operand A; requester i uses bits [8i+7:8i].
- req_b  input  NUM_REQ*8  packed operand B, same packing as req_a.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_product  output  16  registered a*b, unsigned.
- rsp_id  output  ID_W  index of the requester that produced rsp_product.

Behaviour:
- Clock and reset are decided: one clock, clk; reset is synchronous and active-high, rst.
- Reset values (rst sampled high at a clk edge): rsp_valid=0, rsp_product=0, rsp_id=0, priority pointer ptr=0.
- req_ready is forced to all zeros while rst is high.
- Response stage has two states:
  - EMPTY = rsp_valid 0.
  - FULL = rsp_valid 1.
- can_accept = EMPTY, or (FULL and rsp_ready). In the second case, drain and load happen at the same edge.
- Grant (combinational) when can_accept is true:
  - Search req_valid starting at index ptr and wrapping modulo NUM_REQ.
  - The first set bit wins; only that bit of req_ready is driven high.
  - No valid request, or can_accept false: req_ready = 0.
- Accept = req_valid[g] & req_ready[g]. On the accept edge:
  - rsp_product <= req_a[g]*req_b[g], via the shared multiplier, full 16-bit, no truncation.
  - rsp_id <= g; rsp_valid <= 1; ptr <= (g+1) mod NUM_REQ.
- Latency: result is visible on rsp_* the cycle after acceptance (1 cycle).
- Throughput: 1 result/cycle while rsp_ready is held high.
- Drain without accept (FULL, rsp_ready=1, no grant): rsp_valid <= 0. rsp_product and rsp_id hold their last values.
- Backpressure (FULL, rsp_ready=0):
  - rsp_valid, rsp_product and rsp_id are held bit-stable.
  - All req_ready = 0; ptr unchanged.
- ptr changes only on an accept. Idle cycles never rotate priority.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Wrap-around: grant at index NUM_REQ-1 sets ptr=0.
- Requester rule: req_a/req_b are held stable while req_valid is high and ready is low. The arbiter samples operands only on the accept edge.
- req_ready never depends on rsp_product. It depends combinationally on req_valid, rsp_valid, rsp_ready and ptr; no combinational path from ready back to valid.
- Reset mid-operation: a pending result is discarded (rsp_valid=0 the cycle after rst). No request is accepted in any cycle where rst is high.

Decomposition:
- Shared package mult_pkg:
  - MULT_IN_W = 8, MULT_OUT_W = 16.
  - Function for the round-robin wrap search, reusable by other arbiters.
- One sub-module: multiplier_fast, instantiated once on the muxed operands of the granted requester.
- Arbiter logic and response register stay in mult_share_arbiter; no separate FSM module.

Test Plan:
- Single request, operands held: req_valid=0001, a0=5, b0=10, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_product=50, rsp_id=0; following cycle rsp_valid=0.
- All four valid continuously, rsp_ready=1, ptr=0 after reset -> grants 0,1,2,3,0 on consecutive cycles. Products match each pair, e.g. a=1,b=255 -> 255; a=127,b=2 -> 254.
- Backpressure: result 255*255 loaded, rsp_ready=0 for 5 cycles with all req_valid high -> rsp_product=65025 and rsp_id held; req_ready=0 throughout. rsp_ready=1 -> next grant goes to the index after the stalled id, in the same cycle as the drain.
- Pointer/wrap: after a grant to 2, req_valid=1010 -> requester 3 granted, ptr becomes 0. Next cycle, with requester 1 only valid -> requester 1 granted.
- Reset mid-operation: rst=1 while FULL with requests pending -> next cycle rsp_valid=0, rsp_product=0, req_ready=0. After rst falls, the first grant goes to the lowest valid index from 0.
- Random: 2000 cycles of random req_valid, operands ($random % 256) and rsp_ready. Scoreboard per id checks rsp_product === a*b, in-order per requester, and no lost or duplicated transactions.
